// File: rtl/lcd_timing_gen_if.sv
// lcd_timing_gen_if: timing configuration inputs and panel timing outputs of the LCD timing generator
interface lcd_timing_gen_if #(
    parameter int C_HOR_WIDTH = 12,
    parameter int C_VER_WIDTH = 11
);
    logic                   iEn;
    logic [C_HOR_WIDTH-1:0] iHWidth, iHBackPorch, iHFrontPorch, iHResolution;
    logic [C_VER_WIDTH-1:0] iVWidth, iVBackPorch, iVFrontPorch, iVResolution;
    logic                   iHPolarity, iVPolarity, iEnVideoPolarity, iCfgUpdate;
    logic                   oHSynch, oVSynch, oEnVideo;
    logic [C_HOR_WIDTH-1:0] oHAddr;
    logic [C_VER_WIDTH-1:0] oVAddr;
    logic                   oFrameStart, oLineStart, oCfgAck;

    modport master (
        input  iEn, iHWidth, iHBackPorch, iHFrontPorch, iHResolution,
               iVWidth, iVBackPorch, iVFrontPorch, iVResolution,
               iHPolarity, iVPolarity, iEnVideoPolarity, iCfgUpdate,
        output oHSynch, oVSynch, oEnVideo, oHAddr, oVAddr, oFrameStart, oLineStart, oCfgAck
    );

    modport slave (
        output iEn, iHWidth, iHBackPorch, iHFrontPorch, iHResolution,
               iVWidth, iVBackPorch, iVFrontPorch, iVResolution,
               iHPolarity, iVPolarity, iEnVideoPolarity, iCfgUpdate,
        input  oHSynch, oVSynch, oEnVideo, oHAddr, oVAddr, oFrameStart, oLineStart, oCfgAck
    );
endinterface

// File: rtl/lcd_timing_gen.sv
// lcd_timing_gen: LCD/RGB panel sync, data-enable and address generator with frame-aligned timing updates
module lcd_timing_gen #(
    parameter int C_HOR_WIDTH  = 12,
    parameter int C_VER_WIDTH  = 11,
    parameter int C_PIPE_DELAY = 2
) (
    input logic              iClkPixel,
    input logic              iRst,
    lcd_timing_gen_if.master bus
);
    localparam int HW    = C_HOR_WIDTH;
    localparam int VW    = C_VER_WIDTH;
    localparam int HT    = HW + 2;
    localparam int VT    = VW + 2;
    localparam int CFG_W = 4 * HW + 4 * VW + 3;
    localparam int OUT_W = HW + VW + 5;

    typedef enum logic {IDLE, PENDING} state_t;

    state_t           state, nextState;
    logic [CFG_W-1:0] cfgIn, shadow;
    logic [HW-1:0]    hWidth, hBack, hFront, hRes;
    logic [VW-1:0]    vWidth, vBack, vFront, vRes;
    logic             hPol, vPol, dePol;
    logic [HT-1:0]    hCnt, hTotal, hLast, hStart;
    logic [VT-1:0]    vCnt, vTotal, vLast, vStart;
    logic             hEnd, vEnd, frameEnd, doUpdate, lineAct, frameAct, videoAct, cfgAck;
    logic [OUT_W-1:0] curVec, idleVec;
    logic [OUT_W-1:0] pipe [0:C_PIPE_DELAY];

    assign cfgIn = {bus.iHWidth, bus.iHBackPorch, bus.iHFrontPorch, bus.iHResolution,
                    bus.iVWidth, bus.iVBackPorch, bus.iVFrontPorch, bus.iVResolution,
                    bus.iHPolarity, bus.iVPolarity, bus.iEnVideoPolarity};
    assign {hWidth, hBack, hFront, hRes, vWidth, vBack, vFront, vRes, hPol, vPol, dePol} = shadow;
    assign idleVec = {~bus.iHPolarity, ~bus.iVPolarity, ~bus.iEnVideoPolarity, (OUT_W - 3)'(0)};
    assign {bus.oHSynch, bus.oVSynch, bus.oEnVideo, bus.oHAddr, bus.oVAddr,
            bus.oFrameStart, bus.oLineStart} = pipe[C_PIPE_DELAY];
    assign bus.oCfgAck = cfgAck;

    // Frame geometry from the shadow timing; a zero total behaves as a single position
    always_comb begin
        hTotal   = HT'(hWidth) + HT'(hBack) + HT'(hFront) + HT'(hRes);
        vTotal   = VT'(vWidth) + VT'(vBack) + VT'(vFront) + VT'(vRes);
        hLast    = (hTotal == '0) ? '0 : hTotal - HT'(1);
        vLast    = (vTotal == '0) ? '0 : vTotal - VT'(1);
        hStart   = HT'(hWidth) + HT'(hBack);
        vStart   = VT'(vWidth) + VT'(vBack);
        hEnd     = hCnt == hLast;
        vEnd     = vCnt == vLast;
        frameEnd = bus.iEn && hEnd && vEnd;
        lineAct  = hCnt >= hStart && hCnt < hStart + HT'(hRes);
        frameAct = vCnt >= vStart && vCnt < vStart + VT'(vRes);
        videoAct = lineAct && frameAct;
        curVec   = {(hCnt < HT'(hWidth)) ? hPol : ~hPol,
                    (vCnt < VT'(vWidth)) ? vPol : ~vPol,
                    videoAct ? dePol : ~dePol,
                    videoAct ? HW'(hCnt - hStart) : HW'(0),
                    videoAct ? VW'(vCnt - vStart) : VW'(0),
                    hCnt == '0 && vCnt == '0,
                    hCnt == '0};
    end

    // Update request tracking: a request is held until the next end of frame, extra requests merge
    always_comb begin
        doUpdate  = frameEnd && (state == PENDING || bus.iCfgUpdate);
        nextState = doUpdate ? IDLE : (bus.iEn && bus.iCfgUpdate) ? PENDING : state;
    end

    // Update FSM state register
    always_ff @(posedge iClkPixel) begin
        if (!iRst) state <= IDLE;
        else state <= nextState;
    end

    // Counters, shadow timing and output alignment stages; all freeze while iEn is low
    always_ff @(posedge iClkPixel) begin
        if (!iRst) begin
            hCnt   <= '0;
            vCnt   <= '0;
            shadow <= cfgIn;
            cfgAck <= 1'b0;
            for (int i = 0; i <= C_PIPE_DELAY; i++) pipe[i] <= idleVec;
        end else begin
            cfgAck <= doUpdate;
            if (doUpdate) shadow <= cfgIn;
            if (bus.iEn) begin
                hCnt <= hEnd ? '0 : hCnt + HT'(1);
                if (hEnd) vCnt <= vEnd ? '0 : vCnt + VT'(1);
                pipe[0] <= curVec;
                for (int i = 1; i <= C_PIPE_DELAY; i++) pipe[i] <= pipe[i-1];
            end
        end
    end
endmodule

// File: doc/lcd_timing_gen.md
# lcd_timing_gen

Parametrised LCD/RGB panel timing generator. Produces horizontal/vertical sync, data-enable, pixel/line addresses and frame/line markers from runtime timing inputs. Timing is held in shadow registers updated only at frame boundaries, and all outputs are registered with a configurable alignment delay. Sits between the pixel clock domain's configuration registers and the framebuffer read/pixel pipeline.

## Interface
- C_HOR_WIDTH, 12, width of horizontal timing fields and oHAddr
- C_VER_WIDTH, 11, width of vertical timing fields and oVAddr
- C_PIPE_DELAY, 2, extra register stages (0..15) on all outputs, to align with downstream pixel latency

- iClkPixel  in  1  pixel clock; the only clock
- iRst  in  1  synchronous, active-low reset
- iEn  in  1  count enable; low freezes counters and outputs
- iHWidth, iHBackPorch, iHFrontPorch, iHResolution  in  C_HOR_WIDTH each  horizontal timing, in pixels
- iVWidth, iVBackPorch, iVFrontPorch, iVResolution  in  C_VER_WIDTH each  vertical timing, in lines
- iHPolarity, iVPolarity, iEnVideoPolarity  in  1 each  active level of oHSynch, oVSynch, oEnVideo
- iCfgUpdate  in  1  single-cycle request to apply current timing inputs
- oHSynch, oVSynch, oEnVideo  out  1 each  sync and data-enable
- oHAddr  out  C_HOR_WIDTH  pixel index within active line, 0 outside active
- oVAddr  out  C_VER_WIDTH  line index within active frame, 0 outside active
- oFrameStart  out  1  one-cycle pulse at counter position (0,0)
- oLineStart  out  1  one-cycle pulse at each h=0
- oCfgAck  out  1  one-cycle pulse when shadow registers take new values

## Operation
- Shadow set: all timing and polarity inputs. While iRst low, shadow loads inputs every cycle.
- hTotal = HW+HBP+HFP+HRes, vTotal = VW+VBP+VFP+VRes, computed from shadow at C_x_WIDTH+2 bits, no overflow. Total of 0 treated as 1.
- hCnt counts 0..hTotal-1 when iEn high; wraps to 0. vCnt advances by 1 on each hCnt wrap, counts 0..vTotal-1, wraps to 0.
- HS active: hCnt < HW. VS active: vCnt < VW.
- Line active: HW+HBP <= hCnt < HW+HBP+HRes. Frame active: VW+VBP <= vCnt < VW+VBP+VRes.
- oEnVideo active when line active and frame active; then oHAddr = hCnt-(HW+HBP), oVAddr = vCnt-(VW+VBP); otherwise both 0.
- Resolution 0 in either axis: oEnVideo never active.
- Update FSM: IDLE, PENDING. iCfgUpdate in IDLE -> PENDING. At end-of-frame (hCnt=hTotal-1, vCnt=vTotal-1, iEn high) in PENDING: shadow <= inputs, counters wrap to (0,0), oCfgAck pulses next cycle, -> IDLE.
- iCfgUpdate on the end-of-frame cycle itself (IDLE) applies immediately on that boundary. iCfgUpdate while PENDING is absorbed (no queueing); inputs sampled at the boundary.
- Counters never reset mid-frame on update; new totals apply from (0,0).

## Timing
- Reset (iRst low): hCnt=vCnt=0, FSM IDLE, all delay stages flushed; outputs: oHSynch=~iHPolarity, oVSynch=~iVPolarity, oEnVideo=~iEnVideoPolarity, oHAddr=oVAddr=0, oFrameStart=oLineStart=oCfgAck=0.
- First cycle after reset release: counter at (0,0).
- Latency: counter state at cycle t appears on outputs at t+1+C_PIPE_DELAY. All outputs mutually aligned.
- oCfgAck not delayed by C_PIPE_DELAY: asserted cycle after the boundary.
- iEn low: counters, FSM and all delay stages hold; outputs static. Resumes exactly where frozen.
- Reset mid-frame: next cycle returns to reset state; pending update discarded.
- Polarity outputs use shadow polarity: polarity changes only at frame boundary.

## Test plan
- HW=2,HBP=3,HFP=1,HRes=4; VW=1,VBP=1,VFP=1,VRes=3; C_PIPE_DELAY=0 -> hTotal=10, frame=60 cycles; oHSynch active 2 of 10 cycles, oEnVideo active hCnt 5..8 on vCnt 2..4, oHAddr 0..3, oVAddr 0..2; oFrameStart every 60 cycles.
- Same timing, C_PIPE_DELAY=3 -> every output waveform identical, shifted 3 cycles later; oCfgAck unshifted.
- Change HRes 4->6 and pulse iCfgUpdate at mid-frame -> current frame unchanged; oCfgAck one cycle after end-of-frame; next frame hTotal=12, 72 cycles.
- iCfgUpdate asserted exactly on end-of-frame cycle -> applied at that boundary; second iCfgUpdate while PENDING -> single oCfgAck.
- Drop iEn for 5 cycles mid-line -> all outputs hold 5 cycles; frame length becomes 65 cycles.
- Assert iRst (low) at cycle 30 of frame -> outputs at inactive levels next cycle; on release counting restarts at (0,0); oFrameStart at 1+C_PIPE_DELAY cycles after release.
